// File: rtl/addsub_serial_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
// Latency: n/a (types, constants and elaboration helpers only).
// Backpressure: n/a.
// Contents: FSM state encoding, operator codes, slice-count helper, config check.
package addsub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of RUN cycles needed to cover a width-bit word, slice bits at a time.
  function automatic int slice_count(input int width, input int slice);
    return width / slice;
  endfunction

  // A configuration is usable only when the word splits into whole slices.
  function automatic bit slice_cfg_ok(input int width, input int slice);
    return (slice > 0) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One SLICE-bit ripple digit of the serial adder/subtractor.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: x, y  - SLICE-bit operand digits; ci - carry in;
//        sum   - SLICE-bit digit sum; co - carry out of the top bit;
//        c_msb_in - carry into the top bit (feeds signed overflow on the last digit).
module addsub_slice
  import addsub_serial_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             ci,
  output logic [SLICE-1:0] sum,
  output logic             co,
  output logic             c_msb_in
);

  logic [SLICE:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, ci};
  assign sum  = full[SLICE-1:0];
  assign co   = full[SLICE];
  // Sum bit = x ^ y ^ carry_in, so the carry into the top bit falls out of the
  // top sum bit without a second adder. Works for SLICE == 1 as well.
  assign c_msb_in = x[SLICE-1] ^ y[SLICE-1] ^ full[SLICE-1];

endmodule

// File: rtl/addsub_serial.sv
// WIDTH-bit signed/unsigned add/subtract computed one SLICE-bit digit per cycle.
// Latency: start accepted at edge 0, done pulses for the cycle after edge N (N = WIDTH/SLICE).
// Backpressure: ready is high only in IDLE; start is ignored while busy (RUN, DONE).
// Ports: clk, rst (sync, active-high); start/ready request handshake; a, b, cin, operator
//        operands and mode (0 add, 1 subtract); done one-cycle valid pulse;
//        result, carry, overflow, zero, negative held from DONE until the next accepted start.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             operator,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = slice_count(WIDTH, SLICE);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (!slice_cfg_ok(WIDTH, SLICE)) begin : g_cfg_err
      $error("addsub_serial: WIDTH must be a non-zero multiple of SLICE");
    end
  endgenerate

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic             nz_q;  // any non-zero digit produced so far

  logic [SLICE-1:0] s_sum;
  logic             s_co, s_cmsb;
  logic [WIDTH-1:0] res_nx;
  logic             last_slice;

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .x        (a_q[SLICE-1:0]),
    .y        (b_q[SLICE-1:0]),
    .ci       (c_q),
    .sum      (s_sum),
    .co       (s_co),
    .c_msb_in (s_cmsb)
  );

  // New digit enters at the top; after N digits the LSB digit has reached bit 0.
  assign res_nx     = WIDTH'({s_sum, result} >> SLICE);
  assign last_slice = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (last_slice) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      cnt      <= '0;
      nz_q     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            cnt  <= '0;
            nz_q <= 1'b0;
            // Subtract is a + ~b + ~cin: cin acts as a borrow-in.
            case (operator)
              OP_SUB: begin
                b_q <= ~b;
                c_q <= ~cin;
              end
              default: begin
                b_q <= b;
                c_q <= cin;
              end
            endcase
          end
        end
        RUN: begin
          result <= res_nx;
          a_q    <= a_q >> SLICE;
          b_q    <= b_q >> SLICE;
          c_q    <= s_co;
          cnt    <= cnt + 1'b1;
          nz_q   <= nz_q | (|s_sum);
          if (last_slice) begin
            carry    <= s_co;
            overflow <= s_co ^ s_cmsb;
            // Zero is accumulated digit by digit, so no full-width reduction sits
            // behind the carry chain.
            zero     <= ~(nz_q | (|s_sum));
            negative <= s_sum[SLICE-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: 16/4 configuration and the single-slice 8/8 case.
// Latency: n/a.
// Backpressure: n/a.
module tb_addsub_serial;
  import addsub_serial_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit, 4-bit slice instance
  logic        rst16, start16, cin16, op16;
  logic [15:0] a16, b16, res16;
  logic        ready16, done16, carry16, ovf16, zero16, neg16;

  // 8-bit, single slice instance
  logic        rst8, start8, cin8, op8;
  logic [7:0]  a8, b8, res8;
  logic        ready8, done8, carry8, ovf8, zero8, neg8;

  addsub_serial #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .operator(op16), .ready(ready16), .done(done16), .result(res16),
    .carry(carry16), .overflow(ovf16), .zero(zero16), .negative(neg16)
  );

  addsub_serial #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .operator(op8), .ready(ready8), .done(done8), .result(res8),
    .carry(carry8), .overflow(ovf8), .zero(zero8), .negative(neg8)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One operation on the 16-bit instance. With hold set, start stays high and the
  // operand inputs keep changing while the unit is busy.
  task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic op, input bit hold,
                       input logic [15:0] er, input logic ec, input logic ev,
                       input logic ez, input logic en);
    int first_k = 0;
    int pulses  = 0;
    logic [15:0] r = '0;
    logic c = 1'b0, v = 1'b0, z = 1'b0, n = 1'b0, rdy_at_done = 1'b1;
    @(negedge clk);
    a16 = av; b16 = bv; cin16 = ci; op16 = op; start16 = 1'b1;
    @(negedge clk);  // edge 0 has accepted the request
    check_val({tag, ".busy"}, ready16, 1'b0);
    if (!hold) start16 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (hold) begin
        a16   = a16 + 16'h0101;
        b16   = ~b16;
        cin16 = ~cin16;
        op16  = ~op16;
        if (k >= 6) start16 = 1'b0;
      end
      @(negedge clk);  // outputs after edge k
      if (done16) begin
        pulses++;
        if (first_k == 0) begin
          first_k = k; r = res16; c = carry16; v = ovf16; z = zero16; n = neg16;
          rdy_at_done = ready16;
        end
      end
      if (k == 5) check_val({tag, ".ready_back"}, ready16, 1'b1);
    end
    start16 = 1'b0;
    check_val({tag, ".latency"}, first_k, 4);
    check_val({tag, ".pulses"}, pulses, 1);
    check_val({tag, ".rdy_done"}, rdy_at_done, 1'b0);
    check_val({tag, ".result"}, r, er);
    check_val({tag, ".carry"}, c, ec);
    check_val({tag, ".ovf"}, v, ev);
    check_val({tag, ".zero"}, z, ez);
    check_val({tag, ".neg"}, n, en);
    check_val({tag, ".held"}, res16, er);
  endtask

  initial begin
    int pulses;
    rst16 = 1'b1; start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; op16 = OP_ADD;
    rst8  = 1'b1; start8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; op8  = OP_ADD;
    repeat (3) @(negedge clk);
    check_val("rst.ready", ready16, 1'b1);
    check_val("rst.done", done16, 1'b0);
    check_val("rst.result", res16, 16'h0000);
    check_val("rst.flags", {carry16, ovf16, zero16, neg16}, 4'b0000);
    rst16 = 1'b0; rst8 = 1'b0;

    //     tag      a         b         cin   op      hold  result    c     v     z     n
    run16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, OP_ADD, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    run16("sub_neg", 16'h0000, 16'h0001, 1'b0, OP_SUB, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run16("sub_ovf", 16'h8000, 16'h0001, 1'b0, OP_SUB, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run16("sub_brw", 16'h0005, 16'h0003, 1'b1, OP_SUB, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    run16("add_zero", 16'hFFFF, 16'h0000, 1'b1, OP_ADD, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run16("busy",    16'h1234, 16'h1111, 1'b0, OP_ADD, 1'b1, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort mid-operation: reset lands in the 2nd RUN cycle with start held high.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; op16 = OP_ADD; start16 = 1'b1;
    @(negedge clk);  // after edge 0: 1st RUN cycle
    a16 = 16'hAAAA;
    @(negedge clk);  // after edge 1: 2nd RUN cycle
    rst16 = 1'b1;
    @(negedge clk);  // after edge 2: reset taken
    check_val("abort.result", res16, 16'h0000);
    check_val("abort.flags", {carry16, ovf16, zero16, neg16}, 4'b0000);
    check_val("abort.done", done16, 1'b0);
    check_val("abort.ready", ready16, 1'b1);
    start16 = 1'b0;
    rst16 = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done16) pulses++;
    end
    check_val("abort.no_done", pulses, 0);

    // Reset and start together in IDLE: reset wins, nothing is accepted.
    @(negedge clk);
    a16 = 16'h0001; b16 = 16'h0001; start16 = 1'b1; rst16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; rst16 = 1'b0;
    check_val("rst_dom.ready", ready16, 1'b1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done16) pulses++;
    end
    check_val("rst_dom.no_done", pulses, 0);

    // Single-slice instance: RUN for one cycle, then DONE.
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h00; cin8 = 1'b1; op8 = OP_ADD; start8 = 1'b1;
    @(negedge clk);  // after edge 0
    start8 = 1'b0;
    check_val("n1.run_done", done8, 1'b0);
    check_val("n1.run_ready", ready8, 1'b0);
    @(negedge clk);  // after the single RUN edge
    check_val("n1.done", done8, 1'b1);
    check_val("n1.result", res8, 8'h80);
    check_val("n1.ovf", ovf8, 1'b1);
    check_val("n1.carry", carry8, 1'b0);
    check_val("n1.neg", neg8, 1'b1);
    @(negedge clk);
    check_val("n1.done_drop", done8, 1'b0);
    check_val("n1.ready_back", ready8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
